// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the round-robin 16:1 mux scheduler.
// rr_pick scans req starting at ptr and wrapping mod 16, returning the first hit.
package mux_sched_pkg;

   localparam int N_REQ = 16;
   localparam int SEL_W = 4;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // Walks the offsets from highest to lowest so the closest requester after ptr is written last and wins.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
      pick_t            p;
      logic [SEL_W-1:0] k;
      p.found = 1'b0;
      p.idx   = ptr;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         k = ptr + SEL_W'(j);
         if (req[k]) begin
            p.found = 1'b1;
            p.idx   = k;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux_16x1.sv
// Plain 16:1 single-bit multiplexer shared by the scheduler.
module mux_16x1 (
   input  logic [15:0] i,
   input  logic [3:0]  s,
   output logic        out
);

   assign out = i[s];

endmodule

// File: rtl/mux_16x1_rr_sched.sv
// Round-robin scheduler driving the 16:1 mux select, holding each grant for up to HOLD
// accepted beats and handing over to the next requester without an idle cycle.
module mux_16x1_rr_sched
   import mux_sched_pkg::*;
#(
   parameter int HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req,
   input  logic [N_REQ-1:0]  i,
   input  logic              out_ready,
   output logic [SEL_W-1:0]  s,
   output logic [N_REQ-1:0]  gnt,
   output logic              out_valid,
   output logic              out
);

   localparam logic [7:0] LAST_BEAT = 8'(HOLD - 1);

   state_t           state, state_nxt;
   logic [SEL_W-1:0] s_nxt, ptr, ptr_nxt, arb_ptr;
   logic [N_REQ-1:0] gnt_nxt;
   logic [7:0]       cnt, cnt_nxt;
   logic             xfer, release_now, mux_out;
   pick_t            pick;

   assign out_valid   = (state == GRANT) && req[s];
   assign xfer        = out_valid && out_ready;
   assign release_now = (state == GRANT) && ((xfer && (cnt == LAST_BEAT)) || !req[s]);

   // On release the search starts just past the outgoing requester, making it lowest priority.
   assign arb_ptr = release_now ? s + 4'd1 : ptr;
   assign pick    = rr_pick(req, arb_ptr);

   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      gnt_nxt   = gnt;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (pick.found) begin
               state_nxt = GRANT;
               s_nxt     = pick.idx;
               gnt_nxt   = N_REQ'(1) << pick.idx;
               cnt_nxt   = 8'd0;
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_nxt = arb_ptr;
               if (pick.found) begin
                  s_nxt   = pick.idx;
                  gnt_nxt = N_REQ'(1) << pick.idx;
                  cnt_nxt = 8'd0;
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
               end
            end else if (xfer) begin
               cnt_nxt = cnt + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         s     <= '0;
         gnt   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         s     <= s_nxt;
         gnt   <= gnt_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   mux_16x1 u_mux (
      .i   (i),
      .s   (s),
      .out (mux_out)
   );

   assign out = mux_out & out_valid;

endmodule

// File: tb/tb_mux_16x1_rr_sched.sv
// Randomised and directed bench for mux_16x1_rr_sched, run on three HOLD settings at once
// against a beat-counting round-robin model.
module tb_mux_16x1_rr_sched;

   localparam int NDUT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0;
   logic [15:0] i = '0;
   logic        out_ready = 1'b0;

   logic [3:0]  s_w   [NDUT];
   logic [15:0] gnt_w [NDUT];
   logic        ov_w  [NDUT];
   logic        out_w [NDUT];

   int vectors = 0;
   int miscompares = 0;

   int m_busy [NDUT];
   int m_s    [NDUT];
   int m_ptr  [NDUT];
   int m_cnt  [NDUT];

   always #5 clk = ~clk;

   mux_16x1_rr_sched #(.HOLD(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req), .i(i), .out_ready(out_ready),
      .s(s_w[0]), .gnt(gnt_w[0]), .out_valid(ov_w[0]), .out(out_w[0])
   );
   mux_16x1_rr_sched #(.HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .i(i), .out_ready(out_ready),
      .s(s_w[1]), .gnt(gnt_w[1]), .out_valid(ov_w[1]), .out(out_w[1])
   );
   mux_16x1_rr_sched #(.HOLD(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req), .i(i), .out_ready(out_ready),
      .s(s_w[2]), .gnt(gnt_w[2]), .out_valid(ov_w[2]), .out(out_w[2])
   );

   function automatic int holdOf(input int d);
      case (d)
         0:       return 4;
         1:       return 1;
         default: return 2;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a grant lasts until HOLD beats are accepted or its requester drops; then search from the next index.
   task automatic modelStep();
      for (int d = 0; d < NDUT; d++) begin
         bit valid, xfer, rel;
         int base;
         if (!rst_n) begin
            m_busy[d] = 0; m_s[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
         end else begin
            valid = (m_busy[d] != 0) && req[m_s[d]];
            xfer  = valid && out_ready;
            rel   = (m_busy[d] != 0) && ((xfer && (m_cnt[d] + 1 == holdOf(d))) || !req[m_s[d]]);
            if (m_busy[d] != 0 && !rel) begin
               if (xfer) m_cnt[d]++;
            end else begin
               base = rel ? (m_s[d] + 1) % 16 : m_ptr[d];
               if (rel) m_ptr[d] = base;
               m_busy[d] = 0;
               for (int j = 15; j >= 0; j--) begin
                  if (req[(base + j) % 16]) begin
                     m_busy[d] = 1;
                     m_s[d]    = (base + j) % 16;
                     m_cnt[d]  = 0;
                  end
               end
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      modelStep();
   end

   // Every falling edge, all outputs of all three instances are held against the model.
   initial forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         logic        ev;
         logic [15:0] eg;
         ev = (m_busy[d] != 0) && req[m_s[d]];
         eg = (m_busy[d] != 0) ? (16'd1 << m_s[d]) : 16'd0;
         checkOutput($sformatf("model s[%0d]", d), 16'(s_w[d]), 16'(m_s[d]));
         checkOutput($sformatf("model gnt[%0d]", d), gnt_w[d], eg);
         checkOutput($sformatf("model out_valid[%0d]", d), 16'(ov_w[d]), 16'(ev));
         checkOutput($sformatf("model out[%0d]", d), 16'(out_w[d]), 16'(ev && i[m_s[d]]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] r, input logic [15:0] d, input logic rdy);
      req       = r;
      i         = d;
      out_ready = rdy;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(16'h0, 16'h0, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] r;

      doReset();
      checkOutput("reset s", 16'(s_w[0]), 16'h0);
      checkOutput("reset gnt", gnt_w[0], 16'h0);
      checkOutput("reset out_valid", 16'(ov_w[0]), 16'h0);

      // Sole requester 0: grant, four beats of 1, then re-granted to itself.
      applyStimulus(16'h0001, 16'h0001, 1'b1);
      tick();
      checkOutput("single gnt", gnt_w[0], 16'h0001);
      checkOutput("single s", 16'(s_w[0]), 16'h0);
      for (int b = 0; b < 4; b++) begin
         checkOutput("single beat out", 16'(out_w[0]), 16'h1);
         tick();
      end
      checkOutput("single regrant gnt", gnt_w[0], 16'h0001);

      // HOLD=1 with everyone requesting: one requester per cycle, wrapping 15 to 0.
      doReset();
      applyStimulus(16'hFFFF, 16'($urandom), 1'b1);
      for (int k = 0; k < 18; k++) begin
         tick();
         checkOutput($sformatf("wrap s step %0d", k), 16'(s_w[1]), 16'(k % 16));
      end

      // HOLD=2 pair 15 and 0 alternate.
      doReset();
      applyStimulus(16'h8000, 16'h0, 1'b0);
      tick();
      checkOutput("pair start s", 16'(s_w[2]), 16'd15);
      applyStimulus(16'h8001, 16'($urandom), 1'b1);
      tick();
      tick();
      checkOutput("pair after 15 s", 16'(s_w[2]), 16'd0);
      tick();
      tick();
      checkOutput("pair after 0 s", 16'(s_w[2]), 16'd15);

      // Stall on requester 3, then exactly four beats before moving to 4.
      doReset();
      applyStimulus(16'h0018, 16'($urandom), 1'b0);
      tick();
      checkOutput("stall start s", 16'(s_w[0]), 16'd3);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput("stall out_valid", 16'(ov_w[0]), 16'h1);
         checkOutput("stall s", 16'(s_w[0]), 16'd3);
      end
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         tick();
         checkOutput($sformatf("stall beat %0d s", b), 16'(s_w[0]), (b < 3) ? 16'd3 : 16'd4);
      end

      // Requester 5 withdraws after one beat while 9 asks.
      doReset();
      applyStimulus(16'h0020, 16'($urandom), 1'b1);
      tick();
      tick();
      req = 16'h0200;
      #1;
      checkOutput("withdraw out_valid", 16'(ov_w[0]), 16'h0);
      tick();
      checkOutput("withdraw s", 16'(s_w[0]), 16'd9);
      checkOutput("withdraw gnt", gnt_w[0], 16'h0200);

      // Asynchronous reset in the middle of a grant on 7.
      doReset();
      applyStimulus(16'h0080, 16'($urandom), 1'b1);
      tick();
      checkOutput("async pre s", 16'(s_w[0]), 16'd7);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async gnt", gnt_w[0], 16'h0);
      checkOutput("async out_valid", 16'(ov_w[0]), 16'h0);
      checkOutput("async s", 16'(s_w[0]), 16'h0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("async regrant s", 16'(s_w[0]), 16'd7);
      checkOutput("async regrant gnt", gnt_w[0], 16'h0080);

      // Random traffic: requests mostly persist so grants run through several beats.
      doReset();
      r = 16'($urandom);
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 9) < 3) begin
            r = 16'($urandom) & 16'($urandom);
         end
         applyStimulus(r, 16'($urandom), ($urandom_range(0, 3) != 0));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
